// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU: opcodes, FSM states
// and bit positions of the packed status register.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_NAND = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_ERR  = 4;
  localparam int FLAG_BITS = 5;

  function automatic logic [FLAG_BITS-1:0] pack_flags(input logic z, input logic n,
                                                      input logic c, input logic v,
                                                      input logic e);
    logic [FLAG_BITS-1:0] f;
    f           = '0;
    f[FLAG_Z]   = z;
    f[FLAG_N]   = n;
    f[FLAG_C]   = c;
    f[FLAG_V]   = v;
    f[FLAG_ERR] = e;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per clock.
// done/prod are valid combinationally during the final step cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] step_sum;

  // The last step's sum is handed out directly so the parent can register it
  // on the same edge the multiplier retires.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod     = step_sum;
  assign busy     = busy_q;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus an
// iterative multiply, valid/ready on both sides, registered result and flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [FLAG_BITS-1:0] flags_q, flags_d;

  logic                 accept, consume;
  logic                 mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  logic [WIDTH:0]       sum, diff;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c, sc_v, sc_err;

  // in_ready follows out_ready combinationally in DONE so a draining result
  // and a new operation can share one edge.
  assign in_ready = rst && !mul_busy &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SHW-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
    case (op)
      ALU_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = ~diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_NAND: sc_res = ~(a & b);
      ALU_NOR:  sc_res = ~(a | b);
      ALU_AND:  sc_res = a & b;
      ALU_OR:   sc_res = a | b;
      ALU_XOR:  sc_res = a ^ b;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  sc_res = a << shamt;
      ALU_SRL:  sc_res = a >> shamt;
      ALU_SRA:  sc_res = $signed(a) >>> shamt;
      ALU_MUL:  sc_res = '0;
      default:  sc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (op == ALU_MUL) begin
            mul_start   = 1'b1;
            state_d     = ST_MUL;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = sc_res;
            flags_d     = pack_flags(sc_res == '0, sc_res[WIDTH-1], sc_c, sc_v, sc_err);
          end
        end else if (consume) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = mul_prod[WIDTH-1:0];
          flags_d     = pack_flags(mul_prod[WIDTH-1:0] == '0, mul_prod[WIDTH-1],
                                   |mul_prod[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign err       = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus random operations
// compared against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, err;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: flags returned as {err, v, c, n, z}
  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [4:0] f);
    longint      sx, sy, s;
    logic [63:0] u;
    logic        c, v, e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (o)
      4'd0: begin
        u = 64'(x) + 64'(y); r = u[31:0]; c = u[32];
        s = sx + sy; v = (s != longint'($signed(r)));
      end
      4'd1: begin
        u = 64'(x) - 64'(y); r = u[31:0]; c = (x >= y);
        s = sx - sy; v = (s != longint'($signed(r)));
      end
      4'd2:  r = ~(x & y);
      4'd3:  r = ~(x | y);
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x ^ y;
      4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  r = (x < y) ? 32'd1 : 32'd0;
      4'd9:  r = x << y[4:0];
      4'd10: r = x >> y[4:0];
      4'd11: r = 32'(sx >>> y[4:0]);
      4'd12: begin
        u = 64'(x) * 64'(y); r = u[31:0]; c = (u[63:32] != 0);
      end
      default: e = 1'b1;
    endcase
    f = {e, v, c, r[31], (r == 0)};
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int stall, input string tag);
    logic [31:0] er;
    logic [4:0]  ef;
    int          n;
    logic        ir_seen;
    model(o, x, y, er, ef);
    out_ready = 1'b1;
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    n = 0;
    ir_seen = 1'b0;
    while (!out_valid && n < 100) begin
      ir_seen |= in_ready;
      tick();
      n++;
    end
    check({tag, ".latency"}, 64'(n), (o == 4'd12) ? 64'(W) : 64'd0);
    if (o == 4'd12) check({tag, ".busy_in_ready"}, 64'(ir_seen), 64'd0);
    check({tag, ".result"}, 64'(result), 64'(er));
    check({tag, ".flags"}, 64'({err, flag_v, flag_c, flag_n, flag_z}), 64'(ef));
    $display("op=%0d a=%08h b=%08h -> result=%08h flags=%05b", o, x, y, result,
             {err, flag_v, flag_c, flag_n, flag_z});
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      tick();
      check({tag, ".hold"}, 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, er}));
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    check("drain.out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    logic [31:0] x, y;
    logic [3:0]  o;

    // Power-on reset
    tick();
    tick();
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out", 64'({out_valid, result}), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_release.in_ready", 64'(in_ready), 64'd1);

    do_op(4'd0,  32'h7FFFFFFF, 32'h1, 0, "add_ovf");
    do_op(4'd1,  32'd5, 32'd5, 0, "sub_eq");
    do_op(4'd11, 32'h80000000, 32'h21, 0, "sra");
    do_op(4'd7,  32'hFFFFFFFF, 32'h1, 0, "slt");
    do_op(4'd8,  32'hFFFFFFFF, 32'h1, 0, "sltu");
    do_op(4'd12, 32'h10000, 32'h10000, 0, "mul_wrap");
    do_op(4'd12, 32'd1234, 32'd5678, 0, "mul_small");
    do_op(4'd3,  32'h0, 32'h0, 5, "nor_bp");
    do_op(4'd0,  32'd1, 32'd2, 0, "after_bp");
    do_op(4'd14, 32'h1234, 32'h5678, 0, "illegal");
    do_op(4'd4,  32'hF0, 32'hFF, 0, "clear_err");
    drain();

    // Reset in the middle of a multiply
    out_ready = 1'b1;
    op = 4'd12; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("midmul_rst.in_ready_low", 64'(in_ready), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midmul_rst.after", 64'({out_valid, result, in_ready}), 64'({1'b0, 32'd0, 1'b1}));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= out_valid;
    end
    check("midmul_rst.no_ghost", 64'(seen), 64'd0);

    // Random operations with random backpressure
    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: x = 32'h80000000;
        1: y = x;
        2: y = 32'hFFFFFFFF;
        3: x = 32'h7FFFFFFF;
        default: ;
      endcase
      do_op(o, x, y, $urandom_range(0, 2), "rand");
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath's 4-op combinational ALU, for the EX stage.
- Keeps the add/sub/nand/nor encodings and adds logic, compare, shift and iterative unsigned multiply ops.
- Results are registered and come with status flags.
- Handshakes on valid/ready at both ends, so the hazard unit can stall EX on a busy multiply.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  opcode (ALU_* in alu_pkg)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  carry/not-borrow/mul-high-nonzero (see Behaviour)
- flag_v  out  1  signed overflow (ADD/SUB only, else 0)
- err  out  1  illegal opcode for the current result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-low.
- Reset (rst==0 at a rising edge):
  - state<=IDLE.
  - out_valid, result, all flags and err <= 0.
  - Any in-flight multiply is aborted and discarded.
  - in_ready is 0 while rst==0.
- States:
  - IDLE: in_ready=1.
  - MUL: in_ready=0; iterating.
  - DONE: out_valid=1; in_ready=out_ready, a combinational path that is permitted and documented.
- Transfers: input accepted when in_valid&&in_ready at an edge; output consumed when out_valid&&out_ready at an edge.
- Single-cycle ops, accepted at edge N:
  - result and flags registered at edge N; out_valid=1 from N+1.
  - Transition: IDLE->DONE, or DONE->DONE when a new op is accepted as the old result drains.
  - Throughput is 1/cycle while out_ready=1.
- Opcodes (4-bit):
  - 0 ADD, 1 SUB, 2 NAND, 3 NOR (legacy codes kept).
  - 4 AND, 5 OR, 6 XOR.
  - 7 SLT (signed, result 0/1), 8 SLTU (unsigned, result 0/1).
  - 9 SLL, 10 SRL, 11 SRA.
  - 12 MUL (unsigned, low WIDTH bits).
  - 13-15 illegal.
- MUL:
  - Accepted at edge N -> MUL state, radix-2 shift-add, one bit per cycle.
  - Final product registered at edge N+WIDTH; out_valid from N+WIDTH+1 (latency WIDTH+1).
  - Operands are latched at accept; later changes on a/b/op are ignored.
- DONE with out_ready=0: result, flags and err hold stable; in_ready=0.
- DONE with out_ready=1 and no new input: ->IDLE, out_valid<=0.
- Flags are computed on the final result:
  - flag_c, ADD: carry out of bit WIDTH-1.
  - flag_c, SUB: 1 when a>=b unsigned (no borrow).
  - flag_c, MUL: 1 when the upper WIDTH bits of the full product are nonzero.
  - flag_c, all other ops: 0.
  - flag_v: ADD/SUB two's-complement overflow, else 0.
- Arithmetic wraps modulo 2^WIDTH. Shifts use only b[SHW-1:0]; SRA sign-fills.
- Illegal op: accepted as single-cycle; result=0, flag_z=1, other flags 0, err=1.
- in_valid while busy (MUL, or DONE with out_ready=0): not accepted; the source must hold its request.

Decomposition:
- alu_pkg: ALU_* opcode localparams; state encoding (IDLE/MUL/DONE); flag-bit index constants for packing into the status register.
- Sub-module alu_mul_seq(WIDTH) holds the iterative multiplier.
  - Inputs: start, a, b. Outputs: busy, done (1-cycle), prod[2*WIDTH-1:0].
  - Reset the same as the parent.
- Parent holds the FSM, single-cycle datapath and flag logic.

Test Plan:
- Reset: rst=0 for 2 cycles mid-MUL, then release -> out_valid=0, result=0, in_ready=1 on the first cycle after release; aborted product never appears.
- ADD then SUB, WIDTH=32, out_ready=1:
  - ADD a=0x7FFFFFFF, b=1 -> one cycle later result=0x80000000, v=1, n=1, c=0.
  - Back-to-back SUB a=5, b=5 -> result=0, z=1, c=1.
- Shifts and compares:
  - SRA a=0x80000000, b=0x21 -> 0xC0000000 (amount 1).
  - SLT a=-1, b=1 -> 1.
  - SLTU a=-1, b=1 -> 0.
- MUL a=0x10000, b=0x10000 -> out_valid exactly 33 cycles after accept, result=0, c=1, z=1; in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles after a NOR a=0, b=0 -> result 0xFFFFFFFF held stable, in_ready=0; releasing out_ready with in_valid high accepts the next op in the same cycle.
- Illegal op=14 -> result=0, z=1, err=1; next legal op clears err.
